// File: rtl/vga_sync_porch_pkg.sv
// Shared VGA timing constants and types for the raster generator, renderer and sync logic.
package vga_sync_porch_pkg;

  // Standard 640x480 @ 60 Hz raster, in pixel clocks and lines.
  localparam int VGA_TOTAL_COLS    = 800;
  localparam int VGA_TOTAL_ROWS    = 525;
  localparam int VGA_ACTIVE_COLS   = 640;
  localparam int VGA_ACTIVE_ROWS   = 480;
  localparam int VGA_H_FRONT_PORCH = 16;
  localparam int VGA_H_BACK_PORCH  = 48;
  localparam int VGA_V_FRONT_PORCH = 10;
  localparam int VGA_V_BACK_PORCH  = 33;

  localparam int COUNT_W = 10;
  localparam int COLOR_W = 4;
  localparam int FRAME_W = 8;

  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Timing flags that travel together through the video delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_bits_t;

  // Idle raster state: both syncs high (inactive) and colour blanked.
  localparam sync_bits_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

  // True when pos lies in the inclusive window first..last.
  function automatic logic in_span(input count_t pos, input count_t first, input count_t last);
    return (pos >= first) && (pos <= last);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to line up raster timing with renderer latency.
module sync_delay_line
  import vga_sync_porch_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the sample one stage per clock; reset loads the idle value everywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else begin
      stage[0] <= sample;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_porch.sv
// VGA raster generator: counts, porch-aware syncs aligned to renderer latency, blanking and game tick.
module vga_sync_porch
  import vga_sync_porch_pkg::*;
#(
  parameter int TOTAL_COLS      = VGA_TOTAL_COLS,
  parameter int TOTAL_ROWS      = VGA_TOTAL_ROWS,
  parameter int ACTIVE_COLS     = VGA_ACTIVE_COLS,
  parameter int ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH   = VGA_H_FRONT_PORCH,
  parameter int H_BACK_PORCH    = VGA_H_BACK_PORCH,
  parameter int V_FRONT_PORCH   = VGA_V_FRONT_PORCH,
  parameter int V_BACK_PORCH    = VGA_V_BACK_PORCH,
  parameter int VIDEO_DELAY     = 2,
  parameter int FRAMES_PER_TICK = 30
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [COLOR_W-1:0] i_Red_Video,
  input  logic [COLOR_W-1:0] i_Grn_Video,
  input  logic [COLOR_W-1:0] i_Blu_Video,
  output logic [COUNT_W-1:0] o_Col_Count,
  output logic [COUNT_W-1:0] o_Row_Count,
  output logic               o_Frame_Start,
  output logic               o_Game_Tick,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic [COLOR_W-1:0] o_Red_Video,
  output logic [COLOR_W-1:0] o_Grn_Video,
  output logic [COLOR_W-1:0] o_Blu_Video
);

  localparam int MAX_COUNT = 1 << COUNT_W;

  // Reject timing sets that would give an empty or out-of-frame sync pulse.
  if (TOTAL_COLS > MAX_COUNT || TOTAL_ROWS > MAX_COUNT) begin : g_bad_total
    $error("vga_sync_porch: TOTAL_COLS/TOTAL_ROWS exceed the 10-bit counters");
  end
  if (ACTIVE_COLS < 1 || ACTIVE_COLS + H_FRONT_PORCH >= TOTAL_COLS - H_BACK_PORCH) begin : g_bad_h
    $error("vga_sync_porch: horizontal sync start must be before sync end");
  end
  if (ACTIVE_ROWS < 1 || ACTIVE_ROWS + V_FRONT_PORCH >= TOTAL_ROWS - V_BACK_PORCH) begin : g_bad_v
    $error("vga_sync_porch: vertical sync start must be before sync end");
  end
  if (H_BACK_PORCH < 0 || V_BACK_PORCH < 0 || H_FRONT_PORCH < 0 || V_FRONT_PORCH < 0) begin : g_bad_porch
    $error("vga_sync_porch: porch widths must not be negative");
  end
  if (VIDEO_DELAY < 1 || VIDEO_DELAY > 4) begin : g_bad_delay
    $error("vga_sync_porch: VIDEO_DELAY must be 1..4");
  end
  if (FRAMES_PER_TICK < 1 || FRAMES_PER_TICK > 255) begin : g_bad_tick
    $error("vga_sync_porch: FRAMES_PER_TICK must be 1..255");
  end

  localparam count_t COL_LAST = count_t'(TOTAL_COLS - 1);
  localparam count_t ROW_LAST = count_t'(TOTAL_ROWS - 1);
  localparam count_t ACT_COLS = count_t'(ACTIVE_COLS);
  localparam count_t ACT_ROWS = count_t'(ACTIVE_ROWS);
  localparam count_t HS_FIRST = count_t'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam count_t HS_LAST  = count_t'(TOTAL_COLS - H_BACK_PORCH - 1);
  localparam count_t VS_FIRST = count_t'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam count_t VS_LAST  = count_t'(TOTAL_ROWS - V_BACK_PORCH - 1);
  localparam frame_t TICK_LAST = frame_t'(FRAMES_PER_TICK - 1);

  count_t     col;
  count_t     row;
  frame_t     frame_cnt;
  sync_bits_t raw;
  sync_bits_t delayed;
  logic       frame_start;
  logic       game_tick;

  // Raster position: column runs every clock, row advances on each column wrap.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      col <= '0;
      row <= '0;
    end else if (col == COL_LAST) begin
      col <= '0;
      row <= (row == ROW_LAST) ? '0 : row + count_t'(1);
    end else begin
      col <= col + count_t'(1);
    end
  end

  // Undelayed timing flags for the position currently shown to the renderer.
  always_comb begin
    raw        = SYNC_IDLE;
    raw.hsync  = !in_span(col, HS_FIRST, HS_LAST);
    raw.vsync  = !in_span(row, VS_FIRST, VS_LAST);
    raw.active = (col < ACT_COLS) && (row < ACT_ROWS);
  end

  // Hold the timing flags back by the renderer's latency.
  sync_delay_line #(
    .WIDTH       ($bits(sync_bits_t)),
    .DEPTH       (VIDEO_DELAY),
    .RESET_VALUE (SYNC_IDLE)
  ) u_delay (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .sample  (raw),
    .delayed (delayed)
  );

  // One more stage registers the syncs alongside the captured, blanked colour.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_HSync     <= 1'b1;
      o_VSync     <= 1'b1;
      o_Red_Video <= '0;
      o_Grn_Video <= '0;
      o_Blu_Video <= '0;
    end else begin
      o_HSync     <= delayed.hsync;
      o_VSync     <= delayed.vsync;
      o_Red_Video <= delayed.active ? i_Red_Video : '0;
      o_Grn_Video <= delayed.active ? i_Grn_Video : '0;
      o_Blu_Video <= delayed.active ? i_Blu_Video : '0;
    end
  end

  // The counters sit at (0,0) throughout reset, so the pulse is masked until release.
  assign frame_start = !i_Rst && (col == '0) && (row == '0);
  assign game_tick   = frame_start && (frame_cnt == TICK_LAST);

  // Count frames and restart the tick period on the frame that fires the tick.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= game_tick ? '0 : frame_cnt + frame_t'(1);
    end
  end

  assign o_Col_Count   = col;
  assign o_Row_Count   = row;
  assign o_Frame_Start = frame_start;
  assign o_Game_Tick   = game_tick;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch: three small-raster instances and one default-timing instance
// checked every cycle against a position-arithmetic reference model.
module tb_vga_sync_porch;

  localparam int NDUT = 4;

  // Small raster used for whole-frame runs: sync 28..33 and rows 14..16.
  localparam int S_TC  = 40;
  localparam int S_TR  = 20;
  localparam int S_AC  = 24;
  localparam int S_AR  = 12;
  localparam int S_HFP = 4;
  localparam int S_HBP = 6;
  localparam int S_VFP = 2;
  localparam int S_VBP = 3;
  localparam int S_FRAME = S_TC * S_TR;

  typedef struct {
    int tc, tr, ac, ar, hfp, hbp, vfp, vbp, dly, fpt;
  } cfg_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] red_in  [NDUT];
  logic [3:0] grn_in  [NDUT];
  logic [3:0] blu_in  [NDUT];
  logic [9:0] col_cnt [NDUT];
  logic [9:0] row_cnt [NDUT];
  logic       frame_start [NDUT];
  logic       game_tick   [NDUT];
  logic       hsync [NDUT];
  logic       vsync [NDUT];
  logic [3:0] red_out [NDUT];
  logic [3:0] grn_out [NDUT];
  logic [3:0] blu_out [NDUT];

  int          n;
  int          mode;
  int          total;
  int          passed;
  logic [11:0] hist [NDUT][8];
  int          fs_cnt;
  int          h_low;
  int          v_low;
  int          tick_cnt [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_small
    localparam int DLY = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int FPT = (g == 0) ? 3 : (g == 1) ? 1 : 2;
    vga_sync_porch #(
      .TOTAL_COLS(S_TC), .TOTAL_ROWS(S_TR), .ACTIVE_COLS(S_AC), .ACTIVE_ROWS(S_AR),
      .H_FRONT_PORCH(S_HFP), .H_BACK_PORCH(S_HBP), .V_FRONT_PORCH(S_VFP), .V_BACK_PORCH(S_VBP),
      .VIDEO_DELAY(DLY), .FRAMES_PER_TICK(FPT)
    ) dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_Red_Video(red_in[g]), .i_Grn_Video(grn_in[g]), .i_Blu_Video(blu_in[g]),
      .o_Col_Count(col_cnt[g]), .o_Row_Count(row_cnt[g]),
      .o_Frame_Start(frame_start[g]), .o_Game_Tick(game_tick[g]),
      .o_HSync(hsync[g]), .o_VSync(vsync[g]),
      .o_Red_Video(red_out[g]), .o_Grn_Video(grn_out[g]), .o_Blu_Video(blu_out[g])
    );
  end

  vga_sync_porch dut_default (
    .i_Clk(clk), .i_Rst(rst),
    .i_Red_Video(red_in[3]), .i_Grn_Video(grn_in[3]), .i_Blu_Video(blu_in[3]),
    .o_Col_Count(col_cnt[3]), .o_Row_Count(row_cnt[3]),
    .o_Frame_Start(frame_start[3]), .o_Game_Tick(game_tick[3]),
    .o_HSync(hsync[3]), .o_VSync(vsync[3]),
    .o_Red_Video(red_out[3]), .o_Grn_Video(grn_out[3]), .o_Blu_Video(blu_out[3])
  );

  function automatic cfg_t cfg_of(input int k);
    cfg_t c;
    if (k == 3) begin
      c = '{800, 525, 640, 480, 16, 48, 10, 33, 2, 30};
    end else begin
      c = '{S_TC, S_TR, S_AC, S_AR, S_HFP, S_HBP, S_VFP, S_VBP, 2, 3};
      if (k == 1) begin c.dly = 1; c.fpt = 1; end
      if (k == 2) begin c.dly = 4; c.fpt = 2; end
    end
    return c;
  endfunction

  task automatic check_output(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, k, n, obs, expv);
  endtask

  // Renderer model: colour for the position shown dly cycles ago, remembered per position.
  task automatic apply_stimulus();
    for (int k = 0; k < NDUT; k++) begin
      cfg_t        c = cfg_of(k);
      int          p = n - c.dly;
      int          pc = 0;
      int          pr = 0;
      logic [11:0] pix;
      if (p >= 0) begin
        pc = p % c.tc;
        pr = (p / c.tc) % c.tr;
      end
      case (mode)
        0:       pix = 12'($urandom);
        1:       pix = 12'hFFF;
        default: pix = {4'(pc), 4'(pc >> 4), 4'(pr)};
      endcase
      if (p >= 0) hist[k][p % 8] = pix;
      {red_in[k], grn_in[k], blu_in[k]} = pix;
    end
  endtask

  task automatic check_frame();
    for (int k = 0; k < NDUT; k++) begin
      cfg_t c = cfg_of(k);
      int frame = c.tc * c.tr;
      int ec = n % c.tc;
      int er = (n / c.tc) % c.tr;
      int efs = (n % frame == 0) ? 1 : 0;
      int etick = (efs == 1 && ((n / frame) + 1) % c.fpt == 0) ? 1 : 0;
      int m = n - c.dly - 1;
      int eh = 1;
      int ev = 1;
      int ergb = 0;
      if (m >= 0) begin
        int mc = m % c.tc;
        int mr = (m / c.tc) % c.tr;
        eh = (mc >= c.ac + c.hfp && mc < c.tc - c.hbp) ? 0 : 1;
        ev = (mr >= c.ar + c.vfp && mr < c.tr - c.vbp) ? 0 : 1;
        if (mc < c.ac && mr < c.ar) ergb = 32'(hist[k][m % 8]);
      end
      check_output("col", k, 32'(col_cnt[k]), 32'(ec));
      check_output("row", k, 32'(row_cnt[k]), 32'(er));
      check_output("frame_start", k, 32'(frame_start[k]), 32'(efs));
      check_output("game_tick", k, 32'(game_tick[k]), 32'(etick));
      check_output("hsync", k, 32'(hsync[k]), 32'(eh));
      check_output("vsync", k, 32'(vsync[k]), 32'(ev));
      check_output("colour", k, 32'({red_out[k], grn_out[k], blu_out[k]}), 32'(ergb));
      if (game_tick[k]) tick_cnt[k]++;
    end
    if (frame_start[0]) fs_cnt++;
    if (!hsync[0]) h_low++;
    if (!vsync[0]) v_low++;
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      check_output({tag, "_col"}, k, 32'(col_cnt[k]), 32'(0));
      check_output({tag, "_row"}, k, 32'(row_cnt[k]), 32'(0));
      check_output({tag, "_frame_start"}, k, 32'(frame_start[k]), 32'(0));
      check_output({tag, "_game_tick"}, k, 32'(game_tick[k]), 32'(0));
      check_output({tag, "_hsync"}, k, 32'(hsync[k]), 32'(1));
      check_output({tag, "_vsync"}, k, 32'(vsync[k]), 32'(1));
      check_output({tag, "_colour"}, k, 32'({red_out[k], grn_out[k], blu_out[k]}), 32'(0));
    end
  endtask

  task automatic run_cycles(input int cycles);
    repeat (cycles) begin
      apply_stimulus();
      @(negedge clk);
      check_frame();
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic clear_tallies();
    fs_cnt = 0;
    h_low  = 0;
    v_low  = 0;
    for (int k = 0; k < NDUT; k++) tick_cnt[k] = 0;
  endtask

  initial begin
    rst    = 1'b1;
    n      = 0;
    mode   = 0;
    total  = 0;
    passed = 0;
    for (int k = 0; k < NDUT; k++) begin
      red_in[k] = '0;
      grn_in[k] = '0;
      blu_in[k] = '0;
    end
    clear_tallies();
    $display("[TB] vga_sync_porch bench starting");

    // Held in reset: idle outputs, counts at the origin, no frame pulse.
    repeat (3) begin
      @(negedge clk);
      check_reset("por");
    end

    // Release and run the first frame with random colour.
    @(posedge clk);
    #1;
    rst = 1'b0;
    n   = 0;
    clear_tallies();
    run_cycles(S_FRAME);
    check_output("frame_starts_in_frame", 0, 32'(fs_cnt), 32'(1));
    check_output("hsync_low_in_frame", 0, 32'(h_low), 32'(S_TR * (S_TC - S_HBP - S_AC - S_HFP)));
    check_output("vsync_low_in_frame", 0, 32'(v_low), 32'((S_TR - S_VBP - S_AR - S_VFP) * S_TC));

    // Eight more frames: nine frame starts in all.
    run_cycles(8 * S_FRAME);
    check_output("ticks_in_9_frames", 0, 32'(tick_cnt[0]), 32'(9 / 3));
    check_output("ticks_in_9_frames", 1, 32'(tick_cnt[1]), 32'(9 / 1));
    check_output("ticks_in_9_frames", 2, 32'(tick_cnt[2]), 32'(9 / 2));

    // Constant full-scale colour, then a renderer echoing its position as colour.
    mode = 1;
    run_cycles(S_FRAME);
    mode = 2;
    run_cycles(8 * S_TC + 15);

    // Mid-frame reset at row 8, column 15 of the small raster.
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    repeat (5) begin
      @(negedge clk);
      check_reset("rst_hold");
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    n   = 0;
    clear_tallies();
    run_cycles(3 * S_FRAME);
    check_output("ticks_after_reset", 0, 32'(tick_cnt[0]), 32'(1));
    check_output("ticks_after_reset", 1, 32'(tick_cnt[1]), 32'(3));
    check_output("ticks_after_reset", 2, 32'(tick_cnt[2]), 32'(1));
    check_output("frame_starts_after_reset", 0, 32'(fs_cnt), 32'(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
